dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-addressed DataMemory. Requester 0 is the CPU load/store port; requester 1 is the secondary master (DMA / test loader).
- Grants one word access at a time using round-robin with an optional bounded lock for atomic read-modify-write.
- Drives the memory's memAdr/writeData/memWrite, registers readData, and returns it with a one-cycle ack pulse.

Parameters:
- LOCK_MAX, 4, max consecutive accesses one requester may hold via lock before forced release (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req0  in  1  requester 0 access request, held until ack0
- we0  in  1  requester 0 write enable (1 = store)
- addr0  in  ADDR_W  requester 0 byte address
- wdata0  in  DATA_W  requester 0 store data
- lock0  in  1  requester 0 requests to keep grant after this access
- ack0  out  1  one-cycle completion pulse to requester 0
- rdata0  out  DATA_W  load data to requester 0, valid while ack0=1
- req1, we1, addr1, wdata1, lock1, ack1, rdata1: same as above, for requester 1
- memAdr  out  ADDR_W  to DataMemory address
- writeData  out  DATA_W  to DataMemory write data
- memWrite  out  1  to DataMemory write strobe
- readData  in  DATA_W  from DataMemory, combinational read
- gnt  out  1  index of current/last granted requester
- busy  out  1  1 when FSM not IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, ack0=ack1=0, rdata0=rdata1=0, memWrite=0, memAdr=0, writeData=0, gnt=0, rr pointer=0 (req0 favoured), lock counter=0.
- States:
  - IDLE: no access in flight.
  - ACCESS: one cycle; memory driven from the granted requester's addr/wdata; memWrite=we of granted requester.
  - RESP: one cycle; ack of granted requester=1.
- IDLE -> ACCESS when any req=1. Single request: grant it. Both requesting: grant rr pointer.
- ACCESS -> RESP unconditionally. At the ACCESS clock edge:
  - load: readData captured into rdata of the granted port;
  - store: memory write occurs at this edge.
- RESP transitions:
  - granted lock=1, its req=1 and lock counter < LOCK_MAX-1: go to ACCESS for the same requester (back-to-back) and increment the lock counter.
  - otherwise: clear the lock counter, set rr pointer to the other requester, and go to ACCESS if any req=1 (arbitrating with the new pointer), else IDLE.
- Latency: request to ack is 2 cycles minimum. Sustained throughput is one access per 2 cycles.
- memWrite is 1 only in ACCESS with we=1; it is 0 in IDLE and RESP. memAdr/writeData hold their last value outside ACCESS.
- Address passes through unmodified; the memory aligns it to a word. The arbiter applies no alignment check.
- Requester inputs are sampled during ACCESS only. Changing them before ack is a protocol violation and is not checked.
- rdata of the non-granted port holds its previous value. rdata after a store is unchanged.
- Lock is ignored when LOCK_MAX consecutive accesses are reached. The other requester is then guaranteed the next grant if it is requesting (starvation bound = LOCK_MAX accesses).
- Reset asserted mid-ACCESS: any write at that edge is suppressed (memWrite forced 0 asynchronously). No ack is issued and the FSM returns to IDLE.
- req dropped during RESP: no re-grant; follow the normal RESP rules.

Test Plan:
- Single load: write mem[0x10]=0xDEADBEEF via req1, then req0 we0=0 addr0=0x10 -> ack0 two cycles after the req0 edge, rdata0=0xDEADBEEF, memWrite never 1.
- Simultaneous stores: req0 addr 0x20 data 0x11111111 and req1 addr 0x24 data 0x22222222 after reset -> req0 served first (ack0 at cycle 2, ack1 at cycle 4), gnt 0 then 1, both words read back correctly.
- Round-robin fairness: both requesting continuous loads for 8 accesses -> grants alternate 0,1,0,1…, each ack spaced 2 cycles.
- Lock bound: LOCK_MAX=4, req0 lock0=1 continuous, req1 pending -> exactly 4 consecutive ack0, then ack1 next, no IDLE between.
- Misaligned address: req0 load addr 0x13 -> rdata0 equals word at 0x10.
- Async reset during ACCESS of a store to 0x30 -> memWrite drops immediately, mem[0x30] unchanged, no ack, outputs at reset values, busy=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and DataMemory bus bundle for dmem_arbiter.
// The slave modport is the arbiter side; master is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              lock0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] memAdr;
  logic [DATA_W-1:0] writeData;
  logic              memWrite;
  logic [DATA_W-1:0] readData;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    output ack0, rdata0,
    input  req1, we1, addr1, wdata1, lock1,
    output ack1, rdata1,
    output memAdr, writeData, memWrite,
    input  readData
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    input  ack0, rdata0,
    output req1, we1, addr1, wdata1, lock1,
    input  ack1, rdata1,
    input  memAdr, writeData, memWrite,
    output readData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the word-addressed DataMemory,
// with a bounded lock for back-to-back atomic accesses by one requester.
module dmem_arbiter #(
  parameter int LOCK_MAX = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           gnt,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX - 1);

  state_t            state, stateNext;
  logic              gntNext;
  logic              rrPtr, rrPtrNext;
  logic [CNT_W-1:0]  lockCnt, lockCntNext;

  logic              selReq, selWe, selLock;
  logic [ADDR_W-1:0] selAddr, adrHold;
  logic [DATA_W-1:0] selWdata, wdHold;
  logic [DATA_W-1:0] rdata0Q, rdata1Q;

  // Both requesting: the pointer wins; otherwise the lone requester wins.
  function automatic logic arbitrate(input logic r0, input logic r1, input logic ptr);
    return (r0 && r1) ? ptr : r1;
  endfunction

  assign selReq   = gnt ? bus.req1   : bus.req0;
  assign selWe    = gnt ? bus.we1    : bus.we0;
  assign selLock  = gnt ? bus.lock1  : bus.lock0;
  assign selAddr  = gnt ? bus.addr1  : bus.addr0;
  assign selWdata = gnt ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rrPtr   <= 1'b0;
      lockCnt <= '0;
    end else begin
      state   <= stateNext;
      gnt     <= gntNext;
      rrPtr   <= rrPtrNext;
      lockCnt <= lockCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    gntNext     = gnt;
    rrPtrNext   = rrPtr;
    lockCntNext = lockCnt;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          stateNext = ACCESS;
          gntNext   = arbitrate(bus.req0, bus.req1, rrPtr);
        end
      end
      ACCESS: stateNext = RESP;
      RESP: begin
        if (selLock && selReq && (lockCnt < LOCK_LIM)) begin
          stateNext   = ACCESS;
          lockCntNext = lockCnt + 1'b1;
        end else begin
          lockCntNext = '0;
          rrPtrNext   = ~gnt;
          if (bus.req0 || bus.req1) begin
            stateNext = ACCESS;
            gntNext   = arbitrate(bus.req0, bus.req1, ~gnt);
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Memory bus is live only during ACCESS; the hold registers keep the last values otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adrHold <= '0;
      wdHold  <= '0;
      rdata0Q <= '0;
      rdata1Q <= '0;
    end else if (state == ACCESS) begin
      adrHold <= selAddr;
      wdHold  <= selWdata;
      if (!selWe) begin
        if (gnt) rdata1Q <= bus.readData;
        else     rdata0Q <= bus.readData;
      end
    end
  end

  // Decoded from the async-reset state, so a reset mid-ACCESS kills memWrite at once.
  assign bus.memWrite  = (state == ACCESS) && selWe;
  assign bus.memAdr    = (state == ACCESS) ? selAddr  : adrHold;
  assign bus.writeData = (state == ACCESS) ? selWdata : wdHold;

  assign bus.ack0   = (state == RESP) && !gnt;
  assign bus.ack1   = (state == RESP) &&  gnt;
  assign bus.rdata0 = rdata0Q;
  assign bus.rdata1 = rdata1Q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single accesses plus
// hand sequences for contention, round-robin, lock bound and async reset.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic gnt;
  logic busy;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.LOCK_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .gnt  (gnt),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory with combinational read
  logic [31:0] mem [0:63];
  assign bus.readData = mem[bus.memAdr[7:2]];
  always @(posedge clk) if (bus.memWrite) mem[bus.memAdr[7:2]] <= bus.writeData;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] lastRd [2];

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearReqs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearReqs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    lastRd[0] = 32'h0;
    lastRd[1] = 32'h0;
  endtask

  task automatic doAccess(input int idx, input logic port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] expRd);
    int cyc;
    logic got, sawWr;
    logic [31:0] rd, exp;
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.lock1 = 1'b0;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; bus.lock0 = 1'b0;
    end
    cyc = 0; got = 1'b0; sawWr = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.memWrite) sawWr = 1'b1;
      got = port ? bus.ack1 : bus.ack0;
    end
    check($sformatf("v%0d ack seen", idx), {31'b0, got}, 32'd1);
    check($sformatf("v%0d latency", idx), cyc, 32'd2);
    check($sformatf("v%0d gnt", idx), {31'b0, gnt}, {31'b0, port});
    check($sformatf("v%0d memWrite seen", idx), {31'b0, sawWr}, {31'b0, we});
    rd  = port ? bus.rdata1 : bus.rdata0;
    exp = we ? lastRd[port] : expRd;
    check($sformatf("v%0d rdata", idx), rd, exp);
    check($sformatf("v%0d other rdata", idx), port ? bus.rdata0 : bus.rdata1, lastRd[~port]);
    lastRd[port] = exp;
    clearReqs();
    @(posedge clk); #1;
    check($sformatf("v%0d ack pulse", idx), {31'b0, bus.ack0 | bus.ack1}, 32'd0);
    check($sformatf("v%0d idle", idx), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, nAck, ack0Cyc, ack1Cyc;
    logic [4:0] lockPat;
    lockPat = 5'b10000;

    vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h13, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h30, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b1, 32'h14, 32'h12345678, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h16, 32'h0,        32'h12345678};
    vecs[7] = '{1'b0, 1'b0, 32'h30, 32'h0,        32'hCAFEF00D};

    bus.addr0 = '0; bus.wdata0 = '0; bus.addr1 = '0; bus.wdata1 = '0;
    rst = 1'b0;
    clearReqs();
    @(posedge clk); #1;
    check("rst ack0", {31'b0, bus.ack0}, 32'd0);
    check("rst ack1", {31'b0, bus.ack1}, 32'd0);
    check("rst rdata0", bus.rdata0, 32'h0);
    check("rst rdata1", bus.rdata1, 32'h0);
    check("rst memWrite", {31'b0, bus.memWrite}, 32'd0);
    check("rst memAdr", bus.memAdr, 32'h0);
    check("rst writeData", bus.writeData, 32'h0);
    check("rst gnt", {31'b0, gnt}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    lastRd[0] = 32'h0;
    lastRd[1] = 32'h0;

    for (int i = 0; i < 8; i++)
      doAccess(i, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRd);

    // Async reset while a store to 0x30 is in ACCESS
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h30; bus.wdata0 = 32'hBADBAD00;
    @(posedge clk); #1;
    check("arst memWrite before", {31'b0, bus.memWrite}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst memWrite", {31'b0, bus.memWrite}, 32'd0);
    check("arst busy", {31'b0, busy}, 32'd0);
    check("arst ack0", {31'b0, bus.ack0}, 32'd0);
    check("arst memAdr", bus.memAdr, 32'h0);
    check("arst writeData", bus.writeData, 32'h0);
    check("arst rdata0", bus.rdata0, 32'h0);
    check("arst gnt", {31'b0, gnt}, 32'd0);
    @(posedge clk); #1;
    check("arst mem30", mem[12], 32'hCAFEF00D);
    check("arst no ack", {31'b0, bus.ack0 | bus.ack1}, 32'd0);
    clearReqs();
    rst = 1'b1;
    lastRd[0] = 32'h0;
    lastRd[1] = 32'h0;
    doAccess(30, 1'b0, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D);

    // Simultaneous stores straight after reset
    doReset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'h11111111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h24; bus.wdata1 = 32'h22222222;
    cyc = 0; ack0Cyc = 0; ack1Cyc = 0;
    while ((ack0Cyc == 0 || ack1Cyc == 0) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ack0) begin
        ack0Cyc = cyc; bus.req0 = 1'b0;
        check("sim gnt at ack0", {31'b0, gnt}, 32'd0);
      end
      if (bus.ack1) begin
        ack1Cyc = cyc; bus.req1 = 1'b0;
        check("sim gnt at ack1", {31'b0, gnt}, 32'd1);
      end
    end
    check("sim ack0 cycle", ack0Cyc, 32'd2);
    check("sim ack1 cycle", ack1Cyc, 32'd4);
    clearReqs();
    @(posedge clk); #1;
    doAccess(40, 1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111);
    doAccess(41, 1'b0, 1'b0, 32'h24, 32'h0, 32'h22222222);

    // Round-robin with both requesting continuously
    doReset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h24;
    cyc = 0; nAck = 0;
    while (nAck < 8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        check($sformatf("rr%0d port", nAck), {31'b0, bus.ack1}, nAck % 2);
        check($sformatf("rr%0d cycle", nAck), cyc, 2 * (nAck + 1));
        if (bus.ack1) check($sformatf("rr%0d rdata1", nAck), bus.rdata1, 32'h22222222);
        else          check($sformatf("rr%0d rdata0", nAck), bus.rdata0, 32'h11111111);
        nAck++;
        if (nAck == 8) clearReqs();
      end
    end
    check("rr ack count", nAck, 32'd8);
    clearReqs();
    @(posedge clk); #1;
    check("rr idle", {31'b0, busy}, 32'd0);

    // Lock bound: four locked accesses for req0, then req1 must win
    doReset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20; bus.lock0 = 1'b1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h24;
    cyc = 0; nAck = 0;
    while (nAck < 5 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        check($sformatf("lock%0d port", nAck), {31'b0, bus.ack1}, {31'b0, lockPat[nAck]});
        check($sformatf("lock%0d cycle", nAck), cyc, 2 * (nAck + 1));
        nAck++;
        if (nAck == 5) clearReqs();
      end
    end
    check("lock ack count", nAck, 32'd5);
    clearReqs();
    @(posedge clk); #1;
    check("lock idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
